// File: rtl/filter_mode_ctrl.sv
// Filter-bank mode controller: debounced next/prev buttons, frame-boundary commit, one blanked flush frame.
// Latency: rgb_out is registered, 1 cycle after DE/source; a press is accepted DEBOUNCE_CYC+3 cycles after the button rises.
// Backpressure: none (free-running pixel stream). Optional FILTER_AUTO_CYCLE_EN steps the mode every AUTO_FRAMES frames.
module filter_mode_ctrl #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int V_RES        = 480,
    parameter int AUTO_FRAMES  = 120
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        btn_next,
    input  logic        btn_prev,
    input  logic        DE,
    input  logic [9:0]  x_pixel,
    input  logic [9:0]  y_pixel,
    input  logic [11:0] raw_rgb,
    input  logic [11:0] gray_rgb,
    input  logic [11:0] morph_rgb,
    input  logic [11:0] blur_rgb,
    input  logic [11:0] edge_rgb,
    input  logic [11:0] retro_rgb,
    input  logic [11:0] cart_rgb,
    output logic [11:0] rgb_out,
    output logic        cart_on_off,
    output logic [2:0]  mode_active,
    output logic [2:0]  mode_pending,
    output logic        blanking
);

    localparam int          CW      = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);
    localparam logic [9:0]  Y_LAST  = 10'(V_RES - 1);

    typedef enum logic [1:0] {S_RUN, S_PEND, S_BLANK} state_t;

    // index 0 = next button, index 1 = prev button
    logic [1:0]        r_sync1, r_sync2, r_db, r_db_q;
    logic [CW-1:0]     r_cnt [2];
    logic              r_de_q;
    state_t            r_state;
    logic [2:0]        r_pending, r_active;
    logic              r_blank, r_cart;
    logic [11:0]       r_rgb;

    logic [1:0]        w_btn;
    logic              w_next_pulse, w_prev_pulse, w_next_evt, w_frame_end;
    logic [2:0]        w_pend_next;
    logic              w_unused;

    assign w_btn        = {btn_prev, btn_next};
    assign w_next_pulse = r_db[0] & ~r_db_q[0];
    assign w_prev_pulse = r_db[1] & ~r_db_q[1];
    assign w_frame_end  = r_de_q & ~DE & (y_pixel == Y_LAST);

    // Synchronise both buttons and accept a new level only after it has been stable long enough
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_q  <= '0;
            r_cnt   <= '{default: '0};
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_db_q  <= r_db;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_cnt[i] <= '0;
                    r_db[i]  <= r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef FILTER_AUTO_CYCLE_EN
    localparam int AW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [AW-1:0] AUTO_MAX = AW'(AUTO_FRAMES - 1);
    logic [AW-1:0] r_frame_cnt;
    logic          w_auto_pulse;

    assign w_auto_pulse = (r_state == S_RUN) && w_frame_end && (r_frame_cnt == AUTO_MAX);
    assign w_unused     = ^x_pixel;

    // Count frames spent idle in RUN; a real press restarts the interval
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (w_next_pulse || w_prev_pulse) begin
            r_frame_cnt <= '0;
        end else if (r_state == S_RUN && w_frame_end) begin
            r_frame_cnt <= (r_frame_cnt == AUTO_MAX) ? '0 : r_frame_cnt + 1'b1;
        end
    end

    assign w_next_evt = w_next_pulse | w_auto_pulse;
`else
    assign w_next_evt = w_next_pulse;
    assign w_unused   = ^{x_pixel, 1'(AUTO_FRAMES)};
`endif

    // Next pending mode: wrap 0..6 in both directions, simultaneous next+prev cancels
    always_comb begin
        w_pend_next = r_pending;
        if (w_next_evt && !w_prev_pulse) begin
            w_pend_next = (r_pending == 3'd6) ? 3'd0 : r_pending + 3'd1;
        end else if (w_prev_pulse && !w_next_evt) begin
            w_pend_next = (r_pending == 3'd0) ? 3'd6 : r_pending - 3'd1;
        end
    end

    // Mode FSM: commit at frame end (using this cycle's press), then blank a full frame to flush line buffers
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_RUN;
            r_pending <= 3'd0;
            r_active  <= 3'd0;
            r_blank   <= 1'b0;
            r_cart    <= 1'b0;
            r_de_q    <= 1'b0;
        end else begin
            r_de_q    <= DE;
            r_pending <= w_pend_next;
            case (r_state)
                S_RUN: begin
                    if (r_pending != r_active) r_state <= S_PEND;
                end
                S_PEND: begin
                    if (w_pend_next == r_active) begin
                        r_state <= S_RUN;
                    end else if (w_frame_end) begin
                        r_active <= w_pend_next;
                        r_cart   <= (w_pend_next == 3'd6);
                        r_blank  <= 1'b1;
                        r_state  <= S_BLANK;
                    end
                end
                S_BLANK: begin
                    if (w_frame_end) begin
                        if (w_pend_next != r_active) begin
                            r_active <= w_pend_next;
                            r_cart   <= (w_pend_next == 3'd6);
                        end else begin
                            r_blank <= 1'b0;
                            r_state <= S_RUN;
                        end
                    end
                end
                default: begin
                    r_state <= S_RUN;
                    r_blank <= 1'b0;
                end
            endcase
        end
    end

    // Registered output mux; unused code 7 falls back to the raw source
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_rgb <= 12'h000;
        end else if (!DE || r_blank) begin
            r_rgb <= 12'h000;
        end else begin
            case (r_active)
                3'd1:    r_rgb <= gray_rgb;
                3'd2:    r_rgb <= morph_rgb;
                3'd3:    r_rgb <= blur_rgb;
                3'd4:    r_rgb <= edge_rgb;
                3'd5:    r_rgb <= retro_rgb;
                3'd6:    r_rgb <= cart_rgb;
                default: r_rgb <= raw_rgb;
            endcase
        end
    end

    assign rgb_out      = r_rgb;
    assign cart_on_off  = r_cart;
    assign mode_active  = r_active;
    assign mode_pending = r_pending;
    assign blanking     = r_blank;

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// Directed bench for filter_mode_ctrl with short debounce and a tiny frame.
// Latency: checks sampled on the falling clock edge after inputs are applied.
// Backpressure: n/a.
module tb_filter_mode_ctrl;

    localparam int DEB  = 4;
    localparam int VRES = 4;

    logic        sys_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        btn_next = 1'b0, btn_prev = 1'b0, DE = 1'b0;
    logic [9:0]  x_pixel = '0, y_pixel = '0;
    logic [11:0] raw_rgb   = 12'h111;
    logic [11:0] gray_rgb  = 12'h222;
    logic [11:0] morph_rgb = 12'h333;
    logic [11:0] blur_rgb  = 12'h444;
    logic [11:0] edge_rgb  = 12'h555;
    logic [11:0] retro_rgb = 12'h666;
    logic [11:0] cart_rgb  = 12'hA5C;
    logic [11:0] rgb_out;
    logic        cart_on_off, blanking;
    logic [2:0]  mode_active, mode_pending;

    int n_run  = 0;
    int n_fail = 0;

    filter_mode_ctrl #(.DEBOUNCE_CYC(DEB), .V_RES(VRES), .AUTO_FRAMES(3)) dut (
        .sys_clk(sys_clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
        .DE(DE), .x_pixel(x_pixel), .y_pixel(y_pixel),
        .raw_rgb(raw_rgb), .gray_rgb(gray_rgb), .morph_rgb(morph_rgb), .blur_rgb(blur_rgb),
        .edge_rgb(edge_rgb), .retro_rgb(retro_rgb), .cart_rgb(cart_rgb),
        .rgb_out(rgb_out), .cart_on_off(cart_on_off), .mode_active(mode_active),
        .mode_pending(mode_pending), .blanking(blanking)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // apply inputs on the falling edge, return on the next falling edge
    task automatic cyc(input logic de, input int y, input int x);
        DE      = de;
        y_pixel = 10'(y);
        x_pixel = 10'(x);
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0);
    endtask

    task automatic press(input logic nxt, input logic prv);
        btn_next = nxt;
        btn_prev = prv;
        idle(10);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        idle(10);
    endtask

    // VRES active lines of 4 pixels + 2 blank pixels, then 2 vertical blank lines
    task automatic frame(input string tag, input logic [11:0] exp);
        for (int y = 0; y < VRES + 2; y++) begin
            for (int x = 0; x < 6; x++) begin
                cyc((y < VRES) && (x < 4), y, x);
                if (y == 1 && x == 1) chk(tag, rgb_out, exp);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(2);
    endtask

    initial begin
        @(negedge sys_clk);
        idle(2);
        chk("rst_rgb", rgb_out, 12'h000);
        chk("rst_cart", 12'(cart_on_off), 12'd0);
        chk("rst_act", 12'(mode_active), 12'd0);
        chk("rst_pend", 12'(mode_pending), 12'd0);
        chk("rst_blank", 12'(blanking), 12'd0);
        reset = 1'b0;
        idle(2);

        // bounce: 2-cycle pulses never reach the debounce count
        for (int i = 0; i < 3; i++) begin
            btn_next = 1'b1; idle(2);
            btn_next = 1'b0; idle(2);
        end
        idle(10);
        chk("bounce_pend", 12'(mode_pending), 12'd0);

        // next: pending moves, active waits for the frame boundary
        press(1'b1, 1'b0);
        chk("nx_pend", 12'(mode_pending), 12'd1);
        chk("nx_act_hold", 12'(mode_active), 12'd0);
        frame("nx_pend_raw", 12'h111);
        chk("nx_act", 12'(mode_active), 12'd1);
        chk("nx_blank", 12'(blanking), 12'd1);
        frame("nx_blank_rgb", 12'h000);
        chk("nx_unblank", 12'(blanking), 12'd0);
        frame("nx_gray", 12'h222);
        idle(1);
        chk("nx_de_low", rgb_out, 12'h000);

        // prev from reset wraps to cartoon
        do_reset();
        press(1'b0, 1'b1);
        chk("pv_pend", 12'(mode_pending), 12'd6);
        frame("pv_raw", 12'h111);
        chk("pv_act", 12'(mode_active), 12'd6);
        chk("pv_cart", 12'(cart_on_off), 12'd1);
        frame("pv_blank_rgb", 12'h000);
        frame("pv_cart_rgb", 12'hA5C);

        // next from 6 wraps to 0, prev cancels: no blank frame
        press(1'b1, 1'b0);
        chk("cx_wrap", 12'(mode_pending), 12'd0);
        press(1'b0, 1'b1);
        chk("cx_pend", 12'(mode_pending), 12'd6);
        frame("cx_rgb", 12'hA5C);
        chk("cx_blank", 12'(blanking), 12'd0);
        chk("cx_act", 12'(mode_active), 12'd6);

        // press while blanking: second blank frame, then mode 2
        do_reset();
        press(1'b1, 1'b0);
        frame("bl_raw", 12'h111);
        press(1'b1, 1'b0);
        chk("bl_pend", 12'(mode_pending), 12'd2);
        chk("bl_act1", 12'(mode_active), 12'd1);
        chk("bl_still", 12'(blanking), 12'd1);
        frame("bl_f1", 12'h000);
        chk("bl_act2", 12'(mode_active), 12'd2);
        chk("bl_again", 12'(blanking), 12'd1);
        frame("bl_f2", 12'h000);
        chk("bl_run", 12'(blanking), 12'd0);
        frame("bl_morph", 12'h333);

        // simultaneous presses are ignored
        press(1'b1, 1'b1);
        chk("both_pend", 12'(mode_pending), 12'd2);

        // async reset mid-frame while pending
        press(1'b1, 1'b0);
        chk("ar_pend", 12'(mode_pending), 12'd3);
        cyc(1'b1, 1, 0);
        cyc(1'b1, 1, 1);
        chk("ar_pre_rgb", rgb_out, 12'h333);
        reset = 1'b1;
        #1;
        chk("ar_rgb", rgb_out, 12'h000);
        chk("ar_act", 12'(mode_active), 12'd0);
        chk("ar_pend0", 12'(mode_pending), 12'd0);
        chk("ar_cart", 12'(cart_on_off), 12'd0);
        @(negedge sys_clk);
        reset = 1'b0;
        idle(2);
        frame("ar_after", 12'h111);
        chk("ar_after_act", 12'(mode_active), 12'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/filter_mode_ctrl.md
Name: filter_mode_ctrl

Overview:
Run-time controller for the video filter bank. It debounces two push-buttons and keeps a pending filter mode. It commits that mode only at a frame boundary, then blanks one full frame so the line-buffered filters (blur, edge) flush stale data. It drives the registered 12-bit RGB output mux and the cartoon filter's on_off enable, and sits between the filter bank outputs and the VGA output stage.

Parameters:
DEBOUNCE_CYC, 1_000_000, number of stable sys_clk cycles before a button level is accepted (10 ms at 100 MHz)
V_RES, 480, active lines per frame; last active line is V_RES-1
AUTO_FRAMES, 120, frames per step in auto-cycle mode (used only with FILTER_AUTO_CYCLE_EN)

Ports:
sys_clk  in  1  system/pixel-domain clock
reset  in  1  asynchronous, active-high reset
btn_next  in  1  raw asynchronous button, advance mode
btn_prev  in  1  raw asynchronous button, step mode back
DE  in  1  display enable from VGA timing
x_pixel  in  10  current pixel column
y_pixel  in  10  current pixel row
raw_rgb  in  12  mode 0 source {r,g,b}
gray_rgb  in  12  mode 1 source
morph_rgb  in  12  mode 2 source (morphology filtered_data)
blur_rgb  in  12  mode 3 source
edge_rgb  in  12  mode 4 source
retro_rgb  in  12  mode 5 source
cart_rgb  in  12  mode 6 source
rgb_out  out  12  selected pixel {r[3:0],g[3:0],b[3:0]}
cart_on_off  out  1  enable to cartoon filter
mode_active  out  3  committed mode 0..6
mode_pending  out  3  requested mode 0..6
blanking  out  1  high while the FSM is in BLANK

Behaviour:
- Reset values: rgb_out=0, cart_on_off=0, mode_active=0, mode_pending=0, blanking=0, FSM=RUN, debounce counters and synchronizers=0.
- Each button: 2-flop synchronizer, then a counter that resets on any level change. The debounced level updates when the counter reaches DEBOUNCE_CYC-1. A rising edge of the debounced level produces a 1-cycle press pulse.
- Pending update on a press pulse:
  - next: pending = (pending==6) ? 0 : pending+1.
  - prev: pending = (pending==0) ? 6 : pending-1.
  - Both pulses in the same cycle: ignored, pending unchanged.
- frame_end: 1-cycle pulse on the DE falling edge while y_pixel==V_RES-1, from a registered copy of DE.
- FSM:
  - RUN: if pending!=active, go to PEND.
  - PEND: if pending==active (presses cancelled out), return to RUN. On frame_end: active<=pending, go to BLANK.
  - BLANK: blanking=1 for the whole next frame. Presses still update pending. On frame_end: if pending!=active then active<=pending and stay in BLANK for another frame; else go to RUN.
- Output mux: registered, 1-cycle latency.
  - rgb_out <= (DE && !blanking) ? src[mode_active] : 12'h000.
  - Mode codes 7 never occur; treat as 0 (raw).
- cart_on_off = (mode_active==6), registered alongside the mode.
- Reset mid-frame or mid-debounce returns to the reset values immediately (asynchronous). The first frame_end after reset release is handled normally.
- frame_end in the same cycle as a press: the press updates pending first and the commit uses the updated pending value.

Optional Feature:
FILTER_AUTO_CYCLE_EN
- Defined: a frame counter counts frame_end pulses while in RUN. When it reaches AUTO_FRAMES-1 it clears and injects a next pulse, using the same wrap rules. Any real button press clears the counter. Counter resets to 0.
- Undefined: no counter logic is present and modes change only via the buttons.

Test Plan:
- DEBOUNCE_CYC=4; btn_next high 10 cycles -> pending 0->1, active stays 0 until frame_end, then active=1, blanking=1 for one frame, rgb_out=0 during DE, then rgb_out=gray_rgb one cycle after DE.
- btn_next pulses lasting 2 cycles (bounce) -> no pending change.
- btn_prev from reset -> pending=6. After commit, cart_on_off=1 and rgb_out=cart_rgb (e.g. 12'hA5C in -> 12'hA5C out).
- next then prev before frame_end -> FSM returns to RUN, no BLANK frame, active stays 0.
- Press during BLANK (active 1 -> pending 2) -> second BLANK frame, then active=2, RUN.
- Assert reset mid-frame while in PEND -> all outputs 0 in the same cycle, mode_active=0.
